// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - select/edge codes, tap bit indices and strobe helper for timer_prescaler
package timer_pkg;

  localparam logic [2:0] CS_DIV2      = 3'd0;
  localparam logic [2:0] CS_DIV8      = 3'd1;
  localparam logic [2:0] CS_DIV32     = 3'd2;
  localparam logic [2:0] CS_DIV64     = 3'd3;
  localparam logic [2:0] CS_DIV1024   = 3'd4;
  localparam logic [2:0] CS_DIV8192   = 3'd5;
  localparam logic [2:0] CS_EXT       = 3'd6;
  localparam logic [2:0] CS_STOP_CASC = 3'd7;

  localparam logic [1:0] ES_RISE = 2'b00;
  localparam logic [1:0] ES_FALL = 2'b01;
  localparam logic [1:0] ES_BOTH = 2'b10;
  localparam logic [1:0] ES_NONE = 2'b11;

  localparam int TAP_DIV2    = 1;
  localparam int TAP_DIV8    = 3;
  localparam int TAP_DIV32   = 5;
  localparam int TAP_DIV64   = 6;
  localparam int TAP_DIV1024 = 10;
  localparam int TAP_DIV8192 = 13;
  localparam int TAP_MAX     = TAP_DIV8192;

  // True when the low n bits of v are all ones.
  function automatic logic low_ones(input logic [TAP_MAX-1:0] v, input int n);
    logic r;
    r = 1'b1;
    for (int i = 0; i < TAP_MAX; i++) begin
      if (i < n) r = r & v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/tmr_ext_edge_det.sv
// rtl/tmr_ext_edge_det.sv - TMCI synchroniser, prev flop and arm-gated rise/fall/both detect
module tmr_ext_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  input  logic ext_in,
  output logic rise,
  output logic fall,
  output logic both
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = arm & s & ~prev_q;
  assign fall = arm & ~s & prev_q;
  assign both = arm & (s ^ prev_q);

endmodule

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - shared prescaler and per-channel cnt_en pulses; TMR_PRESCALER_CASCADE_EN enables ovf cascade
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int PSC_W       = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psc_clr,
  input  logic [NUM_CH-1:0]     ext_clk_in,
  input  logic [3*NUM_CH-1:0]   clk_sel,
  input  logic [2*NUM_CH-1:0]   edge_sel,
  input  logic [NUM_CH-1:0]     ovf_in,
  output logic [NUM_CH-1:0]     cnt_en,
  output logic [PSC_W-1:0]      psc_q
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [ARM_W-1:0]    arm_cnt;
  logic                armed;
  logic [3*NUM_CH-1:0] sel_q;
  logic [5:0]          div_str;
  logic [NUM_CH-1:0]   ch_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q   <= '0;
      arm_cnt <= '0;
      sel_q   <= '1;
      cnt_en  <= '0;
    end else begin
      psc_q <= psc_clr ? '0 : psc_q + PSC_W'(1);
      if (arm_cnt != ARM_DONE) arm_cnt <= arm_cnt + ARM_W'(1);
      sel_q  <= clk_sel;
      cnt_en <= ch_src;
    end
  end

  // Masks a false rise from an input held high through reset while the sync chain fills.
  assign armed = (arm_cnt == ARM_DONE);

  always_comb begin
    div_str    = '0;
    div_str[0] = low_ones(psc_q[TAP_MAX-1:0], TAP_DIV2);
    div_str[1] = low_ones(psc_q[TAP_MAX-1:0], TAP_DIV8);
    div_str[2] = low_ones(psc_q[TAP_MAX-1:0], TAP_DIV32);
    div_str[3] = low_ones(psc_q[TAP_MAX-1:0], TAP_DIV64);
    div_str[4] = low_ones(psc_q[TAP_MAX-1:0], TAP_DIV1024);
    div_str[5] = low_ones(psc_q[TAP_MAX-1:0], TAP_DIV8192);
    if (psc_clr) div_str = '0;
  end

`ifdef TMR_PRESCALER_CASCADE_EN
  logic unused_ovf;
  assign unused_ovf = ovf_in[NUM_CH-1];
`else
  logic unused_ovf;
  assign unused_ovf = ^ovf_in;
`endif

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic rise, fall, both, casc, src;

    tmr_ext_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .arm    (armed),
      .ext_in (ext_clk_in[ch]),
      .rise   (rise),
      .fall   (fall),
      .both   (both)
    );

`ifdef TMR_PRESCALER_CASCADE_EN
    if (ch > 0) begin : g_casc
      assign casc = ovf_in[ch-1];
    end else begin : g_nocasc
      assign casc = 1'b0;
    end
`else
    assign casc = 1'b0;
`endif

    always_comb begin
      src = 1'b0;
      case (sel_q[3*ch +: 3])
        CS_DIV2:    src = div_str[0];
        CS_DIV8:    src = div_str[1];
        CS_DIV32:   src = div_str[2];
        CS_DIV64:   src = div_str[3];
        CS_DIV1024: src = div_str[4];
        CS_DIV8192: src = div_str[5];
        CS_EXT: begin
          case (edge_sel[2*ch +: 2])
            ES_RISE: src = rise;
            ES_FALL: src = fall;
            ES_BOTH: src = both;
            default: src = 1'b0;
          endcase
        end
        default:    src = casc;
      endcase
    end

    assign ch_src[ch] = src;
  end

endmodule
